// File: rtl/systolic_array_gen.sv
// Parametrised N x N output-stationary systolic multiply engine (C = A.B) with internal operand skew.
// Define SYSTOLIC_SAT_EN to make accumulators saturate instead of wrapping.
module systolic_array_gen #(
    parameter int N      = 3,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int K_MAX  = 8,
    parameter int K_W    = $clog2(K_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [K_W-1:0]            k_len,
    input  logic                      acc_keep,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*DATA_W-1:0]       a_col,
    input  logic [N*DATA_W-1:0]       b_row,
    output logic [N*N*ACC_W-1:0]      out,
    output logic                      busy,
    output logic                      done
);

    localparam int DR_W = $clog2(2 * N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_r, next_state_s;
    logic [K_W-1:0]       k_r, beat_r, k_clamp_s;
    logic [DR_W-1:0]      drain_r, drain_last_s;
    logic                 in_ready_r, busy_r, done_r;
    logic                 start_s, hs_s, clear_s, capture_s, last_beat_s;

    logic [DATA_W-1:0]    a_in_s [N][N];
    logic [DATA_W-1:0]    b_in_s [N][N];

    // Accumulate one product; the saturating build pins at all-ones, which is sticky.
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] acc,
                                                 input logic [2*DATA_W-1:0] prod);
        logic [ACC_W-1:0] prod_ext;
`ifdef SYSTOLIC_SAT_EN
        logic [ACC_W:0]   sum;
`endif
        prod_ext                 = {ACC_W{1'b0}};
        prod_ext[2*DATA_W-1:0]   = prod;
`ifdef SYSTOLIC_SAT_EN
        sum = {1'b0, acc} + {1'b0, prod_ext};
        if (sum[ACC_W]) begin
            return {ACC_W{1'b1}};
        end else begin
            return sum[ACC_W-1:0];
        end
`else
        return acc + prod_ext;
`endif
    endfunction

    assign start_s      = (state_r == IDLE) && start;
    assign hs_s         = in_valid && in_ready_r;
    assign clear_s      = start_s && !acc_keep;
    assign k_clamp_s    = (k_len > K_W'(K_MAX)) ? K_W'(K_MAX) : k_len;
    assign last_beat_s  = (beat_r + K_W'(1)) == k_r;
    // An empty job only needs two cycles so that done lands two edges after start.
    assign drain_last_s = (k_r == K_W'(0)) ? DR_W'(1) : DR_W'(2 * N - 1);
    assign capture_s    = (next_state_s == DONE);

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;

    // Next-state logic for the job sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = (k_clamp_s == K_W'(0)) ? DRAIN : LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (hs_s && last_beat_s) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = LOAD;
                end
            end
            DRAIN: begin
                if (drain_r == drain_last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Sequencer state, job counters and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            k_r        <= {K_W{1'b0}};
            beat_r     <= {K_W{1'b0}};
            drain_r    <= {DR_W{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s == LOAD);
            busy_r     <= (next_state_s != IDLE);
            done_r     <= (next_state_s == DONE);
            drain_r    <= (state_r == DRAIN) ? drain_r + DR_W'(1) : {DR_W{1'b0}};
            if (start_s) begin
                k_r    <= k_clamp_s;
                beat_r <= {K_W{1'b0}};
            end else if (hs_s) begin
                beat_r <= beat_r + K_W'(1);
            end
        end
    end

    genvar gi, gj;

    // West-edge skew: row i sees its operand i cycles later than row 0.
    for (gi = 0; gi < N; gi++) begin : g_row_skew
        logic [DATA_W-1:0] dly_r [gi+1];

        // Shift chain fed with zeros whenever no beat is accepted.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int d = 0; d <= gi; d++) dly_r[d] <= {DATA_W{1'b0}};
            end else begin
                dly_r[0] <= hs_s ? a_col[gi*DATA_W +: DATA_W] : {DATA_W{1'b0}};
                for (int d = 1; d <= gi; d++) dly_r[d] <= dly_r[d-1];
            end
        end
        assign a_in_s[gi][0] = dly_r[gi];
    end

    // North-edge skew: column j sees its operand j cycles later than column 0.
    for (gj = 0; gj < N; gj++) begin : g_col_skew
        logic [DATA_W-1:0] dly_r [gj+1];

        // Shift chain fed with zeros whenever no beat is accepted.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int d = 0; d <= gj; d++) dly_r[d] <= {DATA_W{1'b0}};
            end else begin
                dly_r[0] <= hs_s ? b_row[gj*DATA_W +: DATA_W] : {DATA_W{1'b0}};
                for (int d = 1; d <= gj; d++) dly_r[d] <= dly_r[d-1];
            end
        end
        assign b_in_s[0][gj] = dly_r[gj];
    end

    for (gi = 0; gi < N; gi++) begin : g_pe_row
        for (gj = 0; gj < N; gj++) begin : g_pe_col
            logic [ACC_W-1:0]    acc_r, res_r;
            logic [2*DATA_W-1:0] prod_s;

            assign prod_s = {{DATA_W{1'b0}}, a_in_s[gi][gj]} * {{DATA_W{1'b0}}, b_in_s[gi][gj]};

            // Accumulator plus the result copy that stays stable between DONE cycles.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    acc_r <= {ACC_W{1'b0}};
                    res_r <= {ACC_W{1'b0}};
                end else begin
                    acc_r <= clear_s ? {ACC_W{1'b0}} : acc_add(acc_r, prod_s);
                    if (capture_s) res_r <= acc_r;
                end
            end
            assign out[(gi*N+gj)*ACC_W +: ACC_W] = res_r;

            if (gj < N - 1) begin : g_east
                logic [DATA_W-1:0] a_fwd_r;
                // Forward a one hop east.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) a_fwd_r <= {DATA_W{1'b0}};
                    else      a_fwd_r <= a_in_s[gi][gj];
                end
                assign a_in_s[gi][gj+1] = a_fwd_r;
            end

            if (gi < N - 1) begin : g_south
                logic [DATA_W-1:0] b_fwd_r;
                // Forward b one hop south.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) b_fwd_r <= {DATA_W{1'b0}};
                    else      b_fwd_r <= b_in_s[gi][gj];
                end
                assign b_in_s[gi+1][gj] = b_fwd_r;
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_gen.sv
// Randomised scoreboard bench for systolic_array_gen: a matrix-product model predicts each result
// and its done cycle; a negedge monitor pops and compares on every done pulse.
module tb_systolic_array_gen;
    localparam int N      = 3;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int K_MAX  = 8;
    localparam int K_W    = 4;
    localparam int OUT_W  = N * N * ACC_W;

    logic               clk = 1'b0;
    logic               rst, start, acc_keep, in_valid;
    logic [K_W-1:0]     k_len;
    logic [N*DATA_W-1:0] a_col, b_row;
    logic               in_ready, busy, done;
    logic [OUT_W-1:0]   out;

    systolic_array_gen #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_MAX(K_MAX), .K_W(K_W)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_keep(acc_keep),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out(out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [OUT_W-1:0] val; int cyc; } exp_t;
    exp_t        sb_q[$];
    logic [63:0] model_c [N][N];
    logic [DATA_W-1:0] ta [K_MAX][N];
    logic [DATA_W-1:0] tbm [K_MAX][N];
    int          checks = 0;
    int          errors = 0;
    bit          prev_done = 1'b0;

    task automatic chk_vec(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] fold(input logic [63:0] v);
`ifdef SYSTOLIC_SAT_EN
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
`else
        return v & 64'hFFFF_FFFF;
`endif
    endfunction

    function automatic logic [OUT_W-1:0] model_pack();
        logic [OUT_W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                v[(i*N+j)*ACC_W +: ACC_W] = model_c[i][j][ACC_W-1:0];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                model_c[i][j] = 64'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (rst) begin
            if (prev_done) chk_int("busy_after_done", int'(busy), 0);
            if (done) begin
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width done high on consecutive cycles at %0d", cyc);
                end
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got done at cycle %0d want none", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk_vec("result", out, e.val);
                    chk_int("done_cycle", cyc, e.cyc);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic start_job(input int kl, input logic keep, output int s_cyc);
        int t;
        in_valid = 1'b0;
        for (t = 0; t < 100 && busy; t++) tick();
        if (busy) begin
            errors++;
            $display("FAIL idle_wait got busy=1 want 0 after 100 cycles");
        end
        start = 1'b1; k_len = K_W'(kl); acc_keep = keep;
        tick();
        start = 1'b0;
        s_cyc = cyc;
        if (!keep) model_clear();
        chk_int("busy_rise", int'(busy), 1);
        chk_int("ready_rise", int'(in_ready), (kl != 0) ? 1 : 0);
    endtask

    task automatic send_beat(input int b, output bit ok);
        int t;
        ok = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_col[i*DATA_W +: DATA_W] = ta[b][i];
            b_row[i*DATA_W +: DATA_W] = tbm[b][i];
        end
        for (t = 0; t < 50 && !ok; t++) begin
            ok = in_ready;
            tick();
        end
        if (!ok) begin
            errors++;
            $display("FAIL beat_accept got no handshake want beat %0d accepted", b);
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    model_c[i][j] = fold(model_c[i][j] + 64'(ta[b][i]) * 64'(tbm[b][j]));
        end
        in_valid = 1'b0;
    endtask

    // gap_mode: 0 gapless, 1 two idle cycles between beats, 2 random gaps.
    task automatic run_job(input int kl, input logic keep, input int gap_mode,
                           input bit inject_start, input bit junk_after);
        int s_cyc, keff, gaps;
        bit ok;
        exp_t e;
        keff = (kl > K_MAX) ? K_MAX : kl;
        start_job(kl, keep, s_cyc);
        if (keff == 0) begin
            e.val = model_pack(); e.cyc = s_cyc + 2;
            sb_q.push_back(e);
            return;
        end
        for (int b = 0; b < keff; b++) begin
            send_beat(b, ok);
            if (!ok) return;
            if (b == keff - 1) begin
                e.val = model_pack(); e.cyc = cyc + 2 * N;
                sb_q.push_back(e);
            end else begin
                if (inject_start && b == 0) begin
                    start = 1'b1; k_len = K_W'(1); acc_keep = ~keep;
                    tick();
                    start = 1'b0;
                end
                gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 3));
                for (int g = 0; g < gaps; g++) tick();
            end
        end
        if (junk_after) begin
            in_valid = 1'b1;
            a_col = N*DATA_W'($urandom);
            b_row = N*DATA_W'($urandom);
            for (int g = 0; g < 3; g++) tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic load_plan_data();
        int av[3][3] = '{'{1,5,7}, '{3,8,4}, '{4,9,5}};
        int bv[3][3] = '{'{7,8,2}, '{3,6,7}, '{4,7,3}};
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < N; i++) begin
                ta[k][i]  = DATA_W'(av[k][i]);
                tbm[k][i] = DATA_W'(bv[k][i]);
            end
    endtask

    task automatic load_random_data(input bit full);
        for (int k = 0; k < K_MAX; k++)
            for (int i = 0; i < N; i++) begin
                ta[k][i]  = full ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 255));
                tbm[k][i] = full ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 255));
            end
    endtask

    initial begin
        int t, s_cyc;
        bit ok;
        rst = 1'b0; start = 1'b0; acc_keep = 1'b0; in_valid = 1'b0;
        k_len = '0; a_col = '0; b_row = '0;
        model_clear();
        for (int i = 0; i < 3; i++) tick();
        chk_vec("reset_out", out, '0);
        chk_int("reset_in_ready", int'(in_ready), 0);
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_done", int'(done), 0);
        rst = 1'b1;
        tick();

        load_plan_data();
        run_job(3, 1'b0, 0, 1'b0, 1'b0);
        run_job(3, 1'b0, 1, 1'b0, 1'b0);
        run_job(3, 1'b1, 0, 1'b0, 1'b1);

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) begin
                ta[k][i] = 16'hFFFF; tbm[k][i] = 16'hFFFF;
            end
        run_job(2, 1'b0, 0, 1'b0, 1'b0);

        // Reset in the middle of a job discards it.
        load_plan_data();
        start_job(3, 1'b0, s_cyc);
        send_beat(0, ok);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_vec("midreset_out", out, '0);
        chk_int("midreset_in_ready", int'(in_ready), 0);
        chk_int("midreset_busy", int'(busy), 0);
        chk_int("midreset_done", int'(done), 0);
        model_clear();
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        run_job(3, 1'b0, 0, 1'b0, 1'b0);

        run_job(0, 1'b0, 0, 1'b0, 1'b0);
        load_random_data(1'b0);
        run_job(4, 1'b0, 0, 1'b0, 1'b0);
        run_job(0, 1'b1, 0, 1'b0, 1'b0);

        load_plan_data();
        run_job(3, 1'b0, 1, 1'b1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            load_random_data(n[0]);
            run_job(int'($urandom_range(0, 15)), 1'($urandom), 2, 1'($urandom), 1'($urandom));
        end

        for (t = 0; t < 200 && sb_q.size() != 0; t++) tick();
        chk_int("scoreboard_empty", sb_q.size(), 0);
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
